// File: rtl/sa2_cache_read_ctrl_if.sv
// CPU read port and memory line-fetch port of the 2-way cache read controller.
// The controller connects through the slave modport; the CPU/memory side
// (or a testbench standing in for both) uses the master modport.
interface sa2_cache_read_ctrl_if #(
    parameter int TAG_W    = 5,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 4
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam int LINE_W = 8 * (2 ** OFFSET_W);

    logic                       cpu_req;
    logic [ADDR_W-1:0]          cpu_addr;
    logic                       cpu_ready;
    logic                       cpu_valid;
    logic [7:0]                 cpu_data;
    logic                       cpu_hit;
    logic                       flush;
    logic                       mem_req;
    logic [TAG_W+INDEX_W-1:0]   mem_addr;
    logic                       mem_ack;
    logic [LINE_W-1:0]          mem_line;

    modport slave (
        input  cpu_req, cpu_addr, flush, mem_ack, mem_line,
        output cpu_ready, cpu_valid, cpu_data, cpu_hit, mem_req, mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, flush, mem_ack, mem_line,
        input  cpu_ready, cpu_valid, cpu_data, cpu_hit, mem_req, mem_addr
    );
endinterface

// File: rtl/sa2_cache_read_ctrl.sv
// Read controller for a 2-way set-associative byte cache (8 sets, 16-byte lines).
// Holds tag/valid/LRU/data arrays, performs hit lookup, sequences line fills
// from memory and returns the addressed byte over a valid/ready handshake.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss counters.
module sa2_cache_read_ctrl #(
    parameter int OFFSET_W = 4,
    parameter int INDEX_W  = 3,
    parameter int TAG_W    = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sa2_cache_read_ctrl_if.slave   bus
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
`endif
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam int LINE_W = 8 * (2 ** OFFSET_W);
    localparam int SETS   = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_FILL,
        S_RESPOND
    } state_t;

    state_t                     r_state;
    state_t                     w_next;

    logic                       r_ready;
    logic                       r_mem_req;
    logic [TAG_W+INDEX_W-1:0]   r_mem_addr;
    logic [7:0]                 r_cpu_data;
    logic                       r_cpu_hit;
    logic [ADDR_W-1:0]          r_addr;
    logic [LINE_W-1:0]          r_fill_line;

    // Per-way storage; r_lru[set] names the way to evict next
    logic [SETS-1:0]            r_valid [2];
    logic [SETS-1:0]            r_lru;
    logic [TAG_W-1:0]           r_tag   [2][SETS];
    logic [LINE_W-1:0]          r_data  [2][SETS];

    logic [TAG_W-1:0]           w_tag;
    logic [INDEX_W-1:0]         w_idx;
    logic [OFFSET_W-1:0]        w_off;
    logic                       w_hit0;
    logic                       w_hit1;
    logic                       w_hit;
    logic                       w_hit_way;
    logic                       w_victim;
    logic                       w_flush;
    logic                       w_accept;

    function automatic logic [7:0] sel_byte(input logic [LINE_W-1:0] line,
                                            input logic [OFFSET_W-1:0] off);
        return line[{off, 3'b000} +: 8];
    endfunction

    assign w_tag = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx = r_addr[OFFSET_W +: INDEX_W];
    assign w_off = r_addr[OFFSET_W-1:0];

    // Way 0 takes priority if both ways ever match
    assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit     = w_hit0 || w_hit1;
    assign w_hit_way = !w_hit0;

    // Fill into the first empty way, otherwise the least recently used one
    assign w_victim  = !r_valid[0][w_idx] ? 1'b0 :
                       !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];

    // Flush beats a simultaneous request and is only seen while idle
    assign w_flush   = (r_state == S_IDLE) && bus.flush;
    assign w_accept  = (r_state == S_IDLE) && r_ready && !bus.flush && bus.cpu_req;

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_next = S_LOOKUP;
            S_LOOKUP:   w_next = w_hit ? S_RESPOND : S_MISS_REQ;
            S_MISS_REQ: if (bus.mem_ack) w_next = S_FILL;
            S_FILL:     w_next = S_RESPOND;
            S_RESPOND:  w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // State, handshake outputs, valid/LRU bookkeeping; reset abandons any miss
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_cpu_data <= '0;
            r_cpu_hit  <= 1'b0;
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_lru      <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_flush) begin
                        r_valid[0] <= '0;
                        r_valid[1] <= '0;
                        r_lru      <= '0;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_lru[w_idx] <= ~w_hit_way;
                        r_cpu_data   <= sel_byte(r_data[w_hit_way][w_idx], w_off);
                        r_cpu_hit    <= 1'b1;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {w_tag, w_idx};
                    end
                end
                S_MISS_REQ: begin
                    if (bus.mem_ack) begin
                        r_valid[w_victim][w_idx] <= 1'b1;
                        r_lru[w_idx]             <= ~w_victim;
                        r_mem_req                <= 1'b0;
                    end
                end
                S_FILL: begin
                    r_cpu_data <= sel_byte(r_fill_line, w_off);
                    r_cpu_hit  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Request address capture and line/tag storage (no reset needed on data)
    always_ff @(posedge clk) begin
        if (w_accept)
            r_addr <= bus.cpu_addr;
        if ((r_state == S_MISS_REQ) && bus.mem_ack) begin
            r_data[w_victim][w_idx] <= bus.mem_line;
            r_tag[w_victim][w_idx]  <= w_tag;
            r_fill_line             <= bus.mem_line;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Saturating lookup statistics, cleared by reset and by flush
    always_ff @(posedge clk) begin
        if (!reset_n || w_flush) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) begin
                if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
                if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif

    assign bus.cpu_ready = r_ready;
    assign bus.cpu_valid = (r_state == S_RESPOND);
    assign bus.cpu_data  = r_cpu_data;
    assign bus.cpu_hit   = r_cpu_hit;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;
endmodule

// File: tb/tb_sa2_cache_read_ctrl.sv
// Bench for sa2_cache_read_ctrl: directed test-plan steps followed by random
// reads, checked against a per-set recency-list model of the cache and a
// static memory image.
module tb_sa2_cache_read_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sa2_cache_read_ctrl_if bus ();

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    sa2_cache_read_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [256][16];
    logic [4:0] res [8][$];
    int m_hits   = 0;
    int m_misses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [7:0] la);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = mem[la][k];
        return l;
    endfunction

    // Recency list per set, most recent at the back, at most two resident tags
    function automatic logic model_access(input logic [11:0] a);
        logic [4:0] t;
        logic [2:0] s;
        t = a[11:7];
        s = a[6:4];
        for (int i = 0; i < res[s].size(); i++) begin
            if (res[s][i] == t) begin
                res[s].delete(i);
                res[s].push_back(t);
                m_hits++;
                return 1'b1;
            end
        end
        if (res[s].size() == 2) void'(res[s].pop_front());
        res[s].push_back(t);
        m_misses++;
        return 1'b0;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 8; s++) res[s].delete();
        m_hits   = 0;
        m_misses = 0;
    endfunction

    task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
        chk({tag, "_hitcnt"}, 32'(hit_count), 32'(m_hits));
        chk({tag, "_misscnt"}, 32'(miss_count), 32'(m_misses));
`else
        if (tag.len() < 0) chk(tag, 0, 1);
`endif
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (bus.cpu_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk({tag, "_ready_timeout"}, 32'(bus.cpu_ready), 1);
    endtask

    // Issue one read at a negedge and follow it through to the response
    task automatic do_read(input string tag, input logic [11:0] addr, input int delay);
        logic       exp_hit;
        logic [7:0] exp_data;
        logic [7:0] la;
        exp_hit  = model_access(addr);
        la       = addr[11:4];
        exp_data = mem[la][addr[3:0]];
        wait_ready(tag);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        @(posedge clk);
        #1;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = 12'($urandom);
        chk({tag, "_ready_drop"}, 32'(bus.cpu_ready), 0);
        @(negedge clk);
        chk({tag, "_c1_valid"}, 32'(bus.cpu_valid), 0);
        chk({tag, "_c1_memreq"}, 32'(bus.mem_req), 0);
        if (exp_hit) begin
            @(negedge clk);
            chk({tag, "_hit_memreq"}, 32'(bus.mem_req), 0);
        end else begin
            @(negedge clk);
            chk({tag, "_memreq"}, 32'(bus.mem_req), 1);
            chk({tag, "_memaddr"}, 32'(bus.mem_addr), 32'(la));
            chk({tag, "_valid_early"}, 32'(bus.cpu_valid), 0);
            for (int i = 0; i < delay; i++) begin
                bus.cpu_req  = 1'($urandom);
                bus.cpu_addr = 12'($urandom);
                bus.flush    = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                chk({tag, "_stall_memreq"}, 32'(bus.mem_req), 1);
                chk({tag, "_stall_memaddr"}, 32'(bus.mem_addr), 32'(la));
                chk({tag, "_stall_ready"}, 32'(bus.cpu_ready), 0);
                chk({tag, "_stall_valid"}, 32'(bus.cpu_valid), 0);
            end
            bus.cpu_req  = 1'b0;
            bus.flush    = 1'b0;
            bus.mem_ack  = 1'b1;
            bus.mem_line = line_of(la);
            @(posedge clk);
            #1;
            bus.mem_ack  = 1'b0;
            bus.mem_line = {4{$urandom}};
            @(negedge clk);
            chk({tag, "_fill_valid"}, 32'(bus.cpu_valid), 0);
            chk({tag, "_fill_memreq"}, 32'(bus.mem_req), 0);
            @(negedge clk);
        end
        chk({tag, "_valid"}, 32'(bus.cpu_valid), 1);
        chk({tag, "_hit"}, 32'(bus.cpu_hit), 32'(exp_hit));
        chk({tag, "_data"}, 32'(bus.cpu_data), 32'(exp_data));
        @(negedge clk);
        chk({tag, "_valid_pulse"}, 32'(bus.cpu_valid), 0);
        chk({tag, "_ready_back"}, 32'(bus.cpu_ready), 1);
        chk({tag, "_data_hold"}, 32'(bus.cpu_data), 32'(exp_data));
        check_stats(tag);
    endtask

    task automatic do_flush(input string tag, input logic with_req);
        wait_ready(tag);
        bus.flush    = 1'b1;
        bus.cpu_req  = with_req;
        bus.cpu_addr = 12'h125;
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.cpu_req = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_ready_kept"}, 32'(bus.cpu_ready), 1);
            chk({tag, "_no_valid"}, 32'(bus.cpu_valid), 0);
            chk({tag, "_no_memreq"}, 32'(bus.mem_req), 0);
        end
        check_stats(tag);
    endtask

    initial begin
        logic [11:0] a;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        bus.flush    = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.mem_line = '0;
        for (int l = 0; l < 256; l++)
            for (int k = 0; k < 16; k++) mem[l][k] = 8'($urandom);
        for (int k = 0; k < 16; k++) mem[8'h12][k] = 8'(8'h10 + k);

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.cpu_ready), 0);
        chk("rst_valid", 32'(bus.cpu_valid), 0);
        chk("rst_data", 32'(bus.cpu_data), 0);
        chk("rst_hit", 32'(bus.cpu_hit), 0);
        chk("rst_memreq", 32'(bus.mem_req), 0);
        chk("rst_memaddr", 32'(bus.mem_addr), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_up", 32'(bus.cpu_ready), 1);
        model_clear();
        check_stats("rst");

        // Cold miss, then hit in the same line
        do_read("cold", 12'h123, 3);
        chk("cold_byte", 32'(bus.cpu_data), 32'h13);
        do_read("hit", 12'h125, 0);
        chk("hit_byte", 32'(bus.cpu_data), 32'h15);

        // LRU replacement inside set 2
        do_read("lru_a", 12'h1A3, 1);
        do_read("lru_b", 12'h123, 0);
        do_read("lru_c", 12'h223, 2);
        do_read("lru_d", 12'h123, 0);
        do_read("lru_e", 12'h1A3, 0);

        // Long memory stall with noisy CPU inputs
        do_read("stall", 12'h5F7, 10);

        // Flush wins over a simultaneous request
        do_flush("flush", 1'b1);
        do_read("postflush", 12'h125, 1);
        chk("postflush_byte", 32'(bus.cpu_data), 32'h15);

        // Reset in the middle of a miss
        wait_ready("rmid");
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 12'h345;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmid_memreq", 32'(bus.mem_req), 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rmid_drop", 32'(bus.mem_req), 0);
        chk("rmid_ready", 32'(bus.cpu_ready), 0);
        @(negedge clk);
        reset_n      = 1'b1;
        bus.mem_ack  = 1'b1;
        bus.mem_line = line_of(8'h34);
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rmid_no_valid", 32'(bus.cpu_valid), 0);
            chk("rmid_no_memreq", 32'(bus.mem_req), 0);
        end
        check_stats("rmid");
        do_read("rmid_again", 12'h345, 2);

        // Random reads over a small tag pool so hits and evictions mix
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) do_flush("rnd_flush", 1'($urandom));
            a = {5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            do_read("rnd", a, $urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
